// File: rtl/trace_checker.sv
// Lock-step checker: compares each CPU retire against a queue of expected trace
// records and latches the first failure cause and instruction index.
module trace_checker #(
    parameter logic [16:0] TIMEOUT_CYCLES = 17'd100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ret_valid,
    input  logic [15:0] ret_pc,
    input  logic        ret_regwrite,
    input  logic [3:0]  ret_wreg,
    input  logic [15:0] ret_wdata,
    input  logic        ret_memwrite,
    input  logic [15:0] ret_memaddr,
    input  logic [15:0] ret_memdata,
    input  logic        ret_halt,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [1:0]  exp_kind,
    input  logic [15:0] exp_pc,
    input  logic [3:0]  exp_reg,
    input  logic [15:0] exp_addr,
    input  logic [15:0] exp_value,
    output logic        done,
    output logic        pass,
    output logic [2:0]  err_code,
    output logic [15:0] err_inum,
    output logic [15:0] inst_count,
    output logic [16:0] cycle_count
);

    typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

    localparam logic [1:0]  KIND_NOP   = 2'd0;
    localparam logic [1:0]  KIND_REG   = 2'd1;
    localparam logic [1:0]  KIND_STORE = 2'd2;
    localparam logic [1:0]  KIND_HALT  = 2'd3;
    localparam logic [16:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 17'd1;

    state_t state, state_next;

    logic [1:0]  fifo_kind  [4];
    logic [15:0] fifo_pc    [4];
    logic [3:0]  fifo_reg   [4];
    logic [15:0] fifo_addr  [4];
    logic [15:0] fifo_value [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  occupancy;

    logic        push, pop, retire, matched, halt_match, timeout;
    logic [1:0]  ret_kind;
    logic [2:0]  err_next;

    // exp_ready depends only on registered state, so a pop cannot raise it combinationally
    assign exp_ready = rst_n && (state == ST_RUN) && (occupancy != 3'd4);
    assign push      = exp_valid && exp_ready;
    assign retire    = (state == ST_RUN) && ret_valid;
    assign timeout   = (state == ST_RUN) && (cycle_count == TIMEOUT_LAST);
    assign done      = (state != ST_RUN);
    assign pass      = (state == ST_PASS);

    always_comb begin
        ret_kind = KIND_NOP;
        if (ret_regwrite)      ret_kind = KIND_REG;
        else if (ret_halt)     ret_kind = KIND_HALT;
        else if (ret_memwrite) ret_kind = KIND_STORE;
    end

    // Head-of-queue compare; the if-chain order encodes the error priority
    always_comb begin
        err_next   = 3'd0;
        pop        = 1'b0;
        halt_match = 1'b0;
        if (retire) begin
            if (occupancy == 3'd0) begin
                err_next = 3'd6;
            end else begin
                pop = 1'b1;
                if (fifo_kind[rd_ptr] != ret_kind)
                    err_next = 3'd2;
                else if (fifo_pc[rd_ptr] != ret_pc)
                    err_next = 3'd1;
                else if (ret_kind == KIND_REG && fifo_reg[rd_ptr] != ret_wreg)
                    err_next = 3'd3;
                else if (ret_kind == KIND_STORE && fifo_addr[rd_ptr] != ret_memaddr)
                    err_next = 3'd5;
                else if ((ret_kind == KIND_REG && fifo_value[rd_ptr] != ret_wdata) ||
                         (ret_kind == KIND_STORE && fifo_value[rd_ptr] != ret_memdata))
                    err_next = 3'd4;
                else if (ret_kind == KIND_HALT)
                    halt_match = 1'b1;
            end
        end
    end

    assign matched = pop && (err_next == 3'd0);

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (err_next != 3'd0)  state_next = ST_FAIL;
                else if (halt_match)   state_next = ST_PASS;
                else if (timeout)      state_next = ST_FAIL;
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_kind[wr_ptr]  <= exp_kind;
            fifo_pc[wr_ptr]    <= exp_pc;
            fifo_reg[wr_ptr]   <= exp_reg;
            fifo_addr[wr_ptr]  <= exp_addr;
            fifo_value[wr_ptr] <= exp_value;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            occupancy   <= 3'd0;
            inst_count  <= 16'd0;
            cycle_count <= 17'd0;
            err_code    <= 3'd0;
            err_inum    <= 16'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            occupancy <= occupancy + {2'b00, push} - {2'b00, pop};
            if (state == ST_RUN) cycle_count <= cycle_count + 17'd1;
            if (matched) inst_count <= inst_count + 16'd1;
            // A retire error outranks a timeout landing on the same cycle
            if (state == ST_RUN && state_next == ST_FAIL) begin
                err_code <= (err_next != 3'd0) ? err_next : 3'd7;
                err_inum <= inst_count;
            end
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker; the timeout is shortened to 200 cycles so the
// timeout path is exercised quickly.
module tb_trace_checker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ret_valid, ret_regwrite, ret_memwrite, ret_halt;
    logic [15:0] ret_pc, ret_wdata, ret_memaddr, ret_memdata;
    logic [3:0]  ret_wreg;
    logic        exp_valid, exp_ready;
    logic [1:0]  exp_kind;
    logic [15:0] exp_pc, exp_addr, exp_value;
    logic [3:0]  exp_reg;
    logic        done, pass;
    logic [2:0]  err_code;
    logic [15:0] err_inum, inst_count;
    logic [16:0] cycle_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_checker #(.TIMEOUT_CYCLES(17'd200)) dut (
        .clk(clk), .rst_n(rst_n),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_regwrite(ret_regwrite),
        .ret_wreg(ret_wreg), .ret_wdata(ret_wdata), .ret_memwrite(ret_memwrite),
        .ret_memaddr(ret_memaddr), .ret_memdata(ret_memdata), .ret_halt(ret_halt),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_kind(exp_kind),
        .exp_pc(exp_pc), .exp_reg(exp_reg), .exp_addr(exp_addr), .exp_value(exp_value),
        .done(done), .pass(pass), .err_code(err_code), .err_inum(err_inum),
        .inst_count(inst_count), .cycle_count(cycle_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ret_valid = 0; ret_pc = 0; ret_regwrite = 0; ret_wreg = 0; ret_wdata = 0;
        ret_memwrite = 0; ret_memaddr = 0; ret_memdata = 0; ret_halt = 0;
        exp_valid = 0; exp_kind = 0; exp_pc = 0; exp_reg = 0; exp_addr = 0; exp_value = 0;
    endtask

    task automatic set_exp(input logic [1:0] kind, input logic [15:0] pc, input logic [3:0] rg,
                           input logic [15:0] addr, input logic [15:0] value);
        exp_valid = 1; exp_kind = kind; exp_pc = pc; exp_reg = rg; exp_addr = addr; exp_value = value;
    endtask

    task automatic set_ret(input logic [1:0] kind, input logic [15:0] pc, input logic [3:0] rg,
                           input logic [15:0] addr, input logic [15:0] value);
        ret_valid = 1; ret_pc = pc; ret_regwrite = 0; ret_wreg = 0; ret_wdata = 0;
        ret_memwrite = 0; ret_memaddr = 0; ret_memdata = 0; ret_halt = 0;
        case (kind)
            2'd1: begin ret_regwrite = 1; ret_wreg = rg; ret_wdata = value; end
            2'd2: begin ret_memwrite = 1; ret_memaddr = addr; ret_memdata = value; end
            2'd3: ret_halt = 1;
            default: ;
        endcase
    endtask

    task automatic clear_ret;
        ret_valid = 0; ret_regwrite = 0; ret_memwrite = 0; ret_halt = 0;
    endtask

    function automatic logic [1:0] rec_kind(input int i);
        if (i == 9) return 2'd3;
        if (i % 3 == 1) return 2'd1;
        return 2'd0;
    endfunction

    task automatic do_reset;
        idle_inputs();
        rst_n = 0;
        #1;
        checks++;
        if (exp_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_in_reset: got %b expected 0", exp_ready); end
        tick();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({done, pass} !== 2'b00) begin errors++; $display("[TB] FAIL reset_done_pass: got %b expected 00", {done, pass}); end
        checks++;
        if (inst_count !== 16'd0 || cycle_count !== 17'd0) begin errors++;
            $display("[TB] FAIL reset_counts: got inst %0d cycles %0d expected 0 0", inst_count, cycle_count); end
        checks++;
        if (err_code !== 3'd0 || err_inum !== 16'd0) begin errors++;
            $display("[TB] FAIL reset_err: got code %0d inum %0d expected 0 0", err_code, err_inum); end
        checks++;
        if (exp_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", exp_ready); end
    endtask

    task automatic test_pass_flow;
        do_reset();
        set_exp(2'd1, 16'h0000, 4'd1, 16'h0000, 16'h0005); tick();
        set_exp(2'd2, 16'h0002, 4'd0, 16'h0010, 16'h0005); tick();
        set_exp(2'd3, 16'h0004, 4'd0, 16'h0000, 16'h0000); tick();
        exp_valid = 0;
        set_ret(2'd1, 16'h0000, 4'd1, 16'h0000, 16'h0005); tick();
        set_ret(2'd2, 16'h0002, 4'd0, 16'h0010, 16'h0005); tick();
        set_ret(2'd3, 16'h0004, 4'd0, 16'h0000, 16'h0000); tick();
        clear_ret();
        checks++;
        if ({done, pass} !== 2'b11) begin errors++; $display("[TB] FAIL pass_done_pass: got %b expected 11", {done, pass}); end
        checks++;
        if (inst_count !== 16'd3 || err_code !== 3'd0) begin errors++;
            $display("[TB] FAIL pass_inst_err: got inst %0d code %0d expected 3 0", inst_count, err_code); end
        checks++;
        if (cycle_count !== 17'd6) begin errors++; $display("[TB] FAIL pass_cycles: got %0d expected 6", cycle_count); end
        tick();
        checks++;
        if (cycle_count !== 17'd6 || pass !== 1'b1) begin errors++;
            $display("[TB] FAIL pass_hold: got cycles %0d pass %b expected 6 1", cycle_count, pass); end
    endtask

    task automatic test_value_mismatch;
        do_reset();
        set_exp(2'd1, 16'h0000, 4'd1, 16'h0000, 16'h0005); tick();
        set_exp(2'd2, 16'h0002, 4'd0, 16'h0010, 16'h0005); tick();
        set_exp(2'd3, 16'h0004, 4'd0, 16'h0000, 16'h0000); tick();
        exp_valid = 0;
        set_ret(2'd1, 16'h0000, 4'd1, 16'h0000, 16'h0005); tick();
        set_ret(2'd2, 16'h0002, 4'd0, 16'h0010, 16'h0006); tick();
        clear_ret();
        checks++;
        if ({done, pass} !== 2'b10) begin errors++; $display("[TB] FAIL vmis_state: got %b expected 10", {done, pass}); end
        checks++;
        if (err_code !== 3'd4 || err_inum !== 16'd1 || inst_count !== 16'd1) begin errors++;
            $display("[TB] FAIL vmis_err: got code %0d inum %0d inst %0d expected 4 1 1", err_code, err_inum, inst_count); end
        checks++;
        if (exp_ready !== 1'b0) begin errors++; $display("[TB] FAIL vmis_ready: got %b expected 0", exp_ready); end
        set_ret(2'd3, 16'h0004, 4'd0, 16'h0000, 16'h0000); tick();
        clear_ret();
        checks++;
        if (pass !== 1'b0 || inst_count !== 16'd1 || err_code !== 3'd4) begin errors++;
            $display("[TB] FAIL vmis_ignore: got pass %b inst %0d code %0d expected 0 1 4", pass, inst_count, err_code); end
    endtask

    task automatic test_underflow;
        do_reset();
        set_ret(2'd0, 16'h0000, 4'd0, 16'h0000, 16'h0000); tick();
        clear_ret();
        checks++;
        if (err_code !== 3'd6 || err_inum !== 16'd0 || {done, pass} !== 2'b10) begin errors++;
            $display("[TB] FAIL underflow: got code %0d inum %0d done/pass %b expected 6 0 10", err_code, err_inum, {done, pass}); end
        // A record pushed on the same edge is not yet visible to that retire
        do_reset();
        set_exp(2'd0, 16'h0000, 4'd0, 16'h0000, 16'h0000);
        set_ret(2'd0, 16'h0000, 4'd0, 16'h0000, 16'h0000); tick();
        idle_inputs();
        checks++;
        if (err_code !== 3'd6 || done !== 1'b1) begin errors++;
            $display("[TB] FAIL underflow_same_cycle: got code %0d done %b expected 6 1", err_code, done); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_exp(rec_kind(i), 16'(2 * i), 4'(i), 16'h0000, 16'(16'h11 * i)); tick();
        end
        exp_valid = 0;
        #1;
        checks++;
        if (exp_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_full: got %b expected 0", exp_ready); end
        set_exp(rec_kind(4), 16'd8, 4'd4, 16'h0000, 16'h0044);
        set_ret(rec_kind(0), 16'd0, 4'd0, 16'h0000, 16'h0000);
        #1;
        checks++;
        if (exp_ready !== 1'b0) begin errors++; $display("[TB] FAIL ready_during_pop: got %b expected 0", exp_ready); end
        tick();
        idle_inputs();
        checks++;
        if (exp_ready !== 1'b1) begin errors++; $display("[TB] FAIL ready_after_pop: got %b expected 1", exp_ready); end
        for (int i = 4; i < 10; i++) begin
            set_exp(rec_kind(i), 16'(2 * i), 4'(i), 16'h0000, 16'(16'h11 * i));
            set_ret(rec_kind(i - 3), 16'(2 * (i - 3)), 4'(i - 3), 16'h0000, 16'(16'h11 * (i - 3)));
            tick();
        end
        idle_inputs();
        for (int i = 7; i < 10; i++) begin
            set_ret(rec_kind(i), 16'(2 * i), 4'(i), 16'h0000, 16'(16'h11 * i)); tick();
            clear_ret();
            if (i == 8) begin
                checks++;
                if (done !== 1'b0 || inst_count !== 16'd9) begin errors++;
                    $display("[TB] FAIL wrap_midway: got done %b inst %0d expected 0 9", done, inst_count); end
            end
        end
        checks++;
        if (pass !== 1'b1 || inst_count !== 16'd10 || err_code !== 3'd0) begin errors++;
            $display("[TB] FAIL wrap_end: got pass %b inst %0d code %0d expected 1 10 0", pass, inst_count, err_code); end
    endtask

    task automatic test_timeout;
        do_reset();
        set_exp(2'd0, 16'h0000, 4'd0, 16'h0000, 16'h0000); tick();
        exp_valid = 0;
        set_ret(2'd0, 16'h0000, 4'd0, 16'h0000, 16'h0000); tick();
        clear_ret();
        checks++;
        if (done !== 1'b0 || cycle_count !== 17'd2) begin errors++;
            $display("[TB] FAIL timeout_start: got done %b cycles %0d expected 0 2", done, cycle_count); end
        for (int n = 0; n < 400 && !done; n++) tick();
        checks++;
        if (done !== 1'b1) begin errors++; $display("[TB] FAIL timeout_wait: got done %b expected 1", done); end
        checks++;
        if (err_code !== 3'd7 || cycle_count !== 17'd200 || err_inum !== 16'd1 || pass !== 1'b0) begin errors++;
            $display("[TB] FAIL timeout_err: got code %0d cycles %0d inum %0d pass %b expected 7 200 1 0",
                     err_code, cycle_count, err_inum, pass); end
        tick();
        checks++;
        if (cycle_count !== 17'd200) begin errors++; $display("[TB] FAIL timeout_hold: got %0d expected 200", cycle_count); end
    endtask

    task automatic test_reset_mid_run;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_exp(2'd0, 16'(2 * i), 4'd0, 16'h0000, 16'h0000); tick();
        end
        exp_valid = 0;
        for (int i = 0; i < 3; i++) begin
            set_ret(2'd0, 16'(2 * i), 4'd0, 16'h0000, 16'h0000); tick();
        end
        clear_ret();
        set_exp(2'd0, 16'd8, 4'd0, 16'h0000, 16'h0000); tick();
        exp_valid = 0;
        checks++;
        if (inst_count !== 16'd3 || done !== 1'b0) begin errors++;
            $display("[TB] FAIL midrun_before: got inst %0d done %b expected 3 0", inst_count, done); end
        rst_n = 0;
        set_ret(2'd0, 16'd6, 4'd0, 16'h0000, 16'h0000);
        #1;
        checks++;
        if (exp_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrun_ready_in_reset: got %b expected 0", exp_ready); end
        tick();
        rst_n = 1;
        clear_ret();
        #1;
        checks++;
        if (inst_count !== 16'd0 || cycle_count !== 17'd0 || done !== 1'b0 || exp_ready !== 1'b1) begin errors++;
            $display("[TB] FAIL midrun_after: got inst %0d cycles %0d done %b ready %b expected 0 0 0 1",
                     inst_count, cycle_count, done, exp_ready); end
        set_ret(2'd0, 16'd6, 4'd0, 16'h0000, 16'h0000); tick();
        clear_ret();
        checks++;
        if (err_code !== 3'd6 || err_inum !== 16'd0) begin errors++;
            $display("[TB] FAIL midrun_underflow: got code %0d inum %0d expected 6 0", err_code, err_inum); end
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        tick();
        test_reset();
        test_pass_flow();
        test_value_mismatch();
        test_underflow();
        test_back_to_back();
        test_timeout();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 SHALL have these ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ret_valid  in  1  CPU retired one instruction this cycle
- ret_pc  in  16  PC of the retired instruction
- ret_regwrite  in  1  retired instruction wrote the register file
- ret_wreg  in  4  destination register
- ret_wdata  in  16  register write data
- ret_memwrite  in  1  retired instruction wrote memory
- ret_memaddr  in  16  memory address
- ret_memdata  in  16  memory store data
- ret_halt  in  1  retired instruction is HLT
- exp_valid  in  1  expected record offered
- exp_ready  out  1  checker accepts the expected record
- exp_kind  in  2  expected record kind: 0 NOP/branch, 1 REG, 2 STORE, 3 HALT
- exp_pc  in  16  expected PC
- exp_reg  in  4  expected destination register (REG only)
- exp_addr  in  16  expected store address (STORE only)
- exp_value  in  16  expected register data (REG) or store data (STORE)
- done  out  1  check finished, either pass or fail
- pass  out  1  halt matched with no error
- err_code  out  3  first failure cause, 0 = none
- err_inum  out  16  0-based instruction index of the first failure
- inst_count  out  16  number of matched retires
- cycle_count  out  17  cycles spent in RUN

Function
REQ-002 SHALL buffer expected records in a 4-entry FIFO.
- Push on exp_valid && exp_ready.
- exp_ready = (state==RUN) && (occupancy<4).
- exp_ready is registered-state based; a pop in the same cycle does not raise it.
REQ-003 SHALL classify each retire by priority:
- ret_regwrite -> REG
- else ret_halt -> HALT
- else ret_memwrite -> STORE
- else NOP
REQ-004 SHALL compare the FIFO head combinationally with the retire only when state==RUN and ret_valid=1, then pop the head.
REQ-005 Field compare per kind:
- NOP: pc
- REG: pc, reg, value vs ret_wdata
- STORE: pc, addr vs ret_memaddr, value vs ret_memdata
- HALT: pc
REQ-006 Error codes, highest priority first:
- 6 underflow (FIFO empty at retire)
- 2 kind mismatch
- 1 pc mismatch
- 3 reg mismatch
- 5 addr mismatch
- 4 value mismatch
- 7 timeout
REQ-007 State machine RUN/PASS/FAIL, transitions on the next rising edge:
- RUN->FAIL on any error: latch err_code; latch err_inum = inst_count at that retire.
- RUN->PASS when a HALT record matches.
- PASS and FAIL hold until reset.
REQ-008 inst_count SHALL increment by 1 on each matched retire, including the matching HALT, and hold in PASS/FAIL.
REQ-009 cycle_count SHALL increment every cycle in RUN, whether or not ret_valid is high.
- When cycle_count reaches 100000 in RUN with no other error that cycle: RUN->FAIL, err_code=7, err_inum=inst_count.
REQ-010 Outputs:
- done = (state!=RUN)
- pass = (state==PASS)
- err_code and err_inum hold their latched values in FAIL.
REQ-011 In PASS/FAIL SHALL ignore ret_* inputs and accept no records; the FIFO contents are frozen.
REQ-012 Same-cycle push and pop SHALL both take effect: occupancy unchanged, FIFO order preserved.
- A push into an empty FIFO is not visible to a retire in that same cycle; that retire raises underflow.
REQ-013 FIFO pointers SHALL wrap modulo 4 with no loss of entries.

Reset
REQ-014 With rst_n=0 at a rising edge, the block SHALL enter RUN and clear the FIFO (occupancy 0).
- inst_count=0, cycle_count=0, err_code=0, err_inum=0
- done=0, pass=0
- exp_ready=1 from the first cycle after reset
REQ-015 Reset SHALL take effect mid-run or in PASS/FAIL identically, discarding buffered records.
REQ-016 While rst_n=0, exp_ready=0 and retires are ignored.

Verification
REQ-017 Pass flow:
- Push REG(pc 0x0000, r1, 0x0005), STORE(pc 0x0002, addr 0x0010, value 0x0005), HALT(pc 0x0004).
- Drive matching retires.
- Required: done=1, pass=1, inst_count=3, err_code=0 the cycle after the halt retire.
REQ-018 Value mismatch:
- Same records as REQ-017; second retire drives ret_memdata=0x0006.
- Required: FAIL, err_code=4, err_inum=1, inst_count=1; later retires ignored.
REQ-019 Underflow:
- Retire with an empty FIFO.
- Required: err_code=6, err_inum=0, done=1, pass=0.
REQ-020 Backpressure and wrap:
- Push 4 records: exp_ready=0.
- One matching retire: exp_ready=1 next cycle.
- Continue through 10 records: all match in order.
REQ-021 Timeout:
- Never retire a halt.
- Required: FAIL with err_code=7 when cycle_count=100000.
REQ-022 Reset mid-run:
- With 2 records buffered and inst_count=3, assert rst_n=0 for one edge.
- Required: occupancy 0, inst_count=0, state RUN; a following retire raises underflow.
